// File: rtl/dmem_unit.sv
// Multi-cycle word-organised data memory with byte/half/word lanes, load extension and BUSY stall.
// Optional DMEM_PERF_COUNTERS_EN adds saturating read/write/stall counters.
module dmem_unit #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITEDATA,
    input  logic [1:0]  MEM_READ,
    input  logic [1:0]  MEM_WRITE,
    input  logic        LOAD_UNSIGNED,
    output logic [31:0] READDATA,
    output logic        BUSY,
    output logic        MISALIGNED
`ifdef DMEM_PERF_COUNTERS_EN
    ,
    output logic [31:0] READ_COUNT,
    output logic [31:0] WRITE_COUNT,
    output logic [31:0] STALL_COUNT
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [DEPTH];

    logic          req_s, wr_s, access_s, misal_s;
    logic [1:0]    size_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   word_s, load_s, wmask_s, wdata_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;
    logic          unused_addr_s;

    assign unused_addr_s = ^ADDR[31:AW+2];

    // Request decode; the pipeline holds these inputs stable until the end of DONE.
    always_comb begin
        req_s  = (MEM_READ != 2'b00) | (MEM_WRITE != 2'b00);
        wr_s   = (MEM_WRITE != 2'b00);
        size_s = wr_s ? MEM_WRITE : MEM_READ;
        idx_s  = ADDR[AW+1:2];
        misal_s = ((size_s == 2'b10) & ADDR[0]) |
                  ((size_s == 2'b11) & (ADDR[1:0] != 2'b00));
    end

    // Next-state logic: cnt holds the WAIT cycles still to spend, so WAIT lasts WAIT_STATES cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        access_s = 1'b0;
        BUSY     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    BUSY = 1'b1;
                    if (WS == 4'd0) begin
                        access_s = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = WS;
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                BUSY = 1'b1;
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d    = 4'd0;
                    access_s = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane extraction, load extension and store merge mask.
    always_comb begin
        word_s  = mem_q[idx_s];
        byte_s  = word_s[{ADDR[1:0], 3'b000} +: 8];
        half_s  = word_s[{ADDR[1], 4'b0000} +: 16];
        wmask_s = 32'h0000_0000;
        wdata_s = WRITEDATA << {ADDR[1:0], 3'b000};
        case (size_s)
            2'b01: begin
                load_s  = LOAD_UNSIGNED ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
                wmask_s = 32'h0000_00FF << {ADDR[1:0], 3'b000};
            end
            2'b10: begin
                load_s  = LOAD_UNSIGNED ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
                wmask_s = 32'h0000_FFFF << {ADDR[1], 4'b0000};
            end
            2'b11: begin
                load_s  = word_s;
                wmask_s = 32'hFFFF_FFFF;
            end
            default: load_s = 32'h0000_0000;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            READDATA   <= 32'h0000_0000;
            MISALIGNED <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            MISALIGNED <= access_s & misal_s;
            if (access_s & ~wr_s) begin
                READDATA <= misal_s ? 32'h0000_0000 : load_s;
            end
        end
    end

    // Storage array: never reset, and an access aborted by RESET writes nothing.
    always_ff @(posedge CLK) begin
        if (!RESET && access_s && wr_s && !misal_s) begin
            mem_q[idx_s] <= (word_s & ~wmask_s) | (wdata_s & wmask_s);
        end
    end

`ifdef DMEM_PERF_COUNTERS_EN
    // Saturating access and stall counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            READ_COUNT  <= 32'd0;
            WRITE_COUNT <= 32'd0;
            STALL_COUNT <= 32'd0;
        end else begin
            if ((state_q == S_DONE) && wr_s && (WRITE_COUNT != 32'hFFFF_FFFF)) begin
                WRITE_COUNT <= WRITE_COUNT + 32'd1;
            end
            if ((state_q == S_DONE) && !wr_s && (READ_COUNT != 32'hFFFF_FFFF)) begin
                READ_COUNT <= READ_COUNT + 32'd1;
            end
            if (BUSY && (STALL_COUNT != 32'hFFFF_FFFF)) begin
                STALL_COUNT <= STALL_COUNT + 32'd1;
            end
        end
    end
`endif

endmodule
